// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, system byte values, parser state and byte classes.
// Used by both the message parser and the note sender.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_D1,
    ST_WAIT_D2,
    ST_SYSEX
  } parser_state_e;

  typedef enum logic [2:0] {
    BC_DATA,
    BC_CHAN_STATUS,
    BC_SYSEX_START,
    BC_SYS_COMMON,
    BC_REALTIME
  } byte_class_e;

  // Program change and channel aftertouch carry a single data byte.
  function automatic logic has_two_data(input logic [3:0] status_hi);
    return !(status_hi == PROG || status_hi == CH_AT);
  endfunction

endpackage

// File: rtl/midi_message_parser_if.sv
// Byte-in / note-event-out bundle of the MIDI message parser.
// err_count exists only when MIDI_PARSER_ERR_CNT_EN is defined.
interface midi_message_parser_if;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [6:0] note;
  logic [6:0] velocity;
  logic [3:0] channel;
  logic       note_on_stb;
  logic       note_off_stb;
  logic       gate;
`ifdef MIDI_PARSER_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  modport master (
    output rx_byte, rx_valid,
`ifdef MIDI_PARSER_ERR_CNT_EN
    input  err_count,
`endif
    input  note, velocity, channel, note_on_stb, note_off_stb, gate
  );

  modport slave (
    input  rx_byte, rx_valid,
`ifdef MIDI_PARSER_ERR_CNT_EN
    output err_count,
`endif
    output note, velocity, channel, note_on_stb, note_off_stb, gate
  );

endinterface

// File: rtl/midi_message_parser_classifier.sv
// Combinational byte classifier: sorts a received byte into its MIDI class and,
// for channel status bytes, reports whether the message carries two data bytes.
module midi_byte_classifier
  import midi_pkg::*;
(
  input  logic [7:0]  rx_byte,
  output byte_class_e byte_class,
  output logic        two_data
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    byte_class = BC_DATA;
    two_data   = 1'b0;
    if (!rx_byte[7]) begin
      byte_class = BC_DATA;
    end else if (rx_byte < SYSEX_START) begin
      byte_class = BC_CHAN_STATUS;
      two_data   = has_two_data(rx_byte[7:4]);
    end else if (rx_byte == SYSEX_START) begin
      byte_class = BC_SYSEX_START;
    end else if (rx_byte < RT_MIN) begin
      byte_class = BC_SYS_COMMON;
    end else begin
      byte_class = BC_REALTIME;
    end
  end

endmodule

// File: rtl/midi_message_parser.sv
// MIDI receive parser: turns UART RX bytes into registered note-on/off events with running status.
// Define MIDI_PARSER_ERR_CNT_EN to add the saturating err_count output.
module midi_message_parser
  import midi_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter bit OMNI    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  midi_message_parser_if.slave  bus
);

  localparam logic [3:0] CHAN_SEL = 4'(CHANNEL);

  byte_class_e   byte_class;
  logic          byte_two_data;
  parser_state_e state_q, state_nx;

  logic [7:0] status_q;
  logic       two_data_q;
  logic [6:0] d1_q;
  logic [6:0] held_note_q;
  logic [6:0] note_q, velocity_q;
  logic [3:0] channel_q;
  logic       on_stb_q, off_stb_q, gate_q;

  logic       load_status, clear_status, load_d1;
  logic       msg_done, chan_ok, ev_on, ev_off;
  logic [6:0] d2;

  midi_byte_classifier u_classifier (
    .rx_byte    (bus.rx_byte),
    .byte_class (byte_class),
    .two_data   (byte_two_data)
  );

  assign d2 = bus.rx_byte[6:0];

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_nx;
  end

  // Real-time bytes fall through to the default arm and leave the state untouched.
  always_comb begin
    state_nx = state_q;
    if (bus.rx_valid) begin
      case (byte_class)
        BC_SYSEX_START: state_nx = ST_SYSEX;
        BC_SYS_COMMON: begin
          if (state_q != ST_SYSEX || bus.rx_byte == SYSEX_END) state_nx = ST_IDLE;
        end
        BC_CHAN_STATUS: begin
          if (state_q != ST_SYSEX) state_nx = ST_WAIT_D1;
        end
        BC_DATA: begin
          case (state_q)
            ST_WAIT_D1: state_nx = two_data_q ? ST_WAIT_D2 : ST_WAIT_D1;
            ST_WAIT_D2: state_nx = ST_WAIT_D1;
            default:    state_nx = state_q;
          endcase
        end
        default: state_nx = state_q;
      endcase
    end
  end

  always_comb begin
    load_status  = bus.rx_valid && byte_class == BC_CHAN_STATUS && state_q != ST_SYSEX;
    clear_status = bus.rx_valid && (byte_class == BC_SYSEX_START ||
                   (byte_class == BC_SYS_COMMON && state_q != ST_SYSEX));
    load_d1      = bus.rx_valid && byte_class == BC_DATA && state_q == ST_WAIT_D1 && two_data_q;
    msg_done     = bus.rx_valid && byte_class == BC_DATA && state_q == ST_WAIT_D2;
    chan_ok      = OMNI || status_q[3:0] == CHAN_SEL;
    ev_on        = msg_done && chan_ok && status_q[7:4] == NOTE_ON && d2 != 7'd0;
    ev_off       = msg_done && chan_ok &&
                   (status_q[7:4] == NOTE_OFF || (status_q[7:4] == NOTE_ON && d2 == 7'd0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q    <= '0;
      two_data_q  <= 1'b0;
      d1_q        <= '0;
      held_note_q <= '0;
      note_q      <= '0;
      velocity_q  <= '0;
      channel_q   <= '0;
      on_stb_q    <= 1'b0;
      off_stb_q   <= 1'b0;
      gate_q      <= 1'b0;
    end else begin
      if (load_status) begin
        status_q   <= bus.rx_byte;
        two_data_q <= byte_two_data;
      end else if (clear_status) begin
        status_q   <= '0;
        two_data_q <= 1'b0;
      end
      if (load_d1) d1_q <= bus.rx_byte[6:0];
      on_stb_q  <= ev_on;
      off_stb_q <= ev_off;
      if (ev_on || ev_off) begin
        note_q     <= d1_q;
        velocity_q <= d2;
        channel_q  <= status_q[3:0];
      end
      // Only a release of the note currently sounding drops the gate.
      if (ev_on) begin
        gate_q      <= 1'b1;
        held_note_q <= d1_q;
      end else if (ev_off && d1_q == held_note_q) begin
        gate_q <= 1'b0;
      end
    end
  end

`ifdef MIDI_PARSER_ERR_CNT_EN
  logic       err_inc;
  logic [7:0] err_q;

  // Stray data with no running status, or a two-byte message cut short by any status byte.
  assign err_inc = bus.rx_valid &&
                   ((byte_class == BC_DATA && state_q == ST_IDLE) ||
                    (state_q == ST_WAIT_D2 && byte_class != BC_DATA && byte_class != BC_REALTIME));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          err_q <= '0;
    else if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end

  assign bus.err_count = err_q;
`endif

  assign bus.note         = note_q;
  assign bus.velocity     = velocity_q;
  assign bus.channel      = channel_q;
  assign bus.note_on_stb  = on_stb_q;
  assign bus.note_off_stb = off_stb_q;
  assign bus.gate         = gate_q;

endmodule

// File: tb/tb_midi_message_parser.sv
// Directed bench for midi_message_parser: an OMNI instance and a CHANNEL=2 filtered instance
// share one byte stream; expected values are hand-computed per step.
module tb_midi_message_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  int         total = 0;
  int         bad = 0;

  midi_message_parser_if bus_a ();
  midi_message_parser_if bus_b ();

  assign bus_a.rx_byte  = rx_byte;
  assign bus_a.rx_valid = rx_valid;
  assign bus_b.rx_byte  = rx_byte;
  assign bus_b.rx_valid = rx_valid;

  midi_message_parser dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  midi_message_parser #(.CHANNEL(2), .OMNI(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with the byte consumed.
  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_a(input string tag, input logic on, input logic off,
                         input logic [6:0] n, input logic [6:0] v,
                         input logic [3:0] c, input logic g);
    check({tag, ".on"},   32'(bus_a.note_on_stb),  32'(on));
    check({tag, ".off"},  32'(bus_a.note_off_stb), 32'(off));
    check({tag, ".note"}, 32'(bus_a.note),         32'(n));
    check({tag, ".vel"},  32'(bus_a.velocity),     32'(v));
    check({tag, ".ch"},   32'(bus_a.channel),      32'(c));
    check({tag, ".gate"}, 32'(bus_a.gate),         32'(g));
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_a("reset", 0, 0, 7'h00, 7'h00, 4'h0, 0);
    check("reset.b_gate", 32'(bus_b.gate), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic note-on, strobe exactly one cycle after the last data byte.
    send(8'h90); send(8'h45);
    check("on1.early", 32'(bus_a.note_on_stb), 32'd0);
    send(8'h64);
    check_a("on1", 1, 0, 7'h45, 7'h64, 4'h0, 1);
    @(negedge clk);
    check("on1.pulse_end", 32'(bus_a.note_on_stb), 32'd0);

    // Running status on channel 1.
    send(8'h91); send(8'h3C); send(8'h40);
    check_a("rs1", 1, 0, 7'h3C, 7'h40, 4'h1, 1);
    send(8'h3E); send(8'h50);
    check_a("rs2", 1, 0, 7'h3E, 7'h50, 4'h1, 1);

    // Note-on with zero velocity releases the held note.
    send(8'h90); send(8'h3C); send(8'h40);
    send(8'h3C); send(8'h00);
    check_a("off_v0", 0, 1, 7'h3C, 7'h00, 4'h0, 0);
    // Release of a different note leaves the gate high.
    send(8'h90); send(8'h3C); send(8'h40);
    send(8'h3D); send(8'h00);
    check_a("off_other", 0, 1, 7'h3D, 7'h00, 4'h0, 1);
    // True note-off for the held note, even after an unrelated release.
    send(8'h80); send(8'h3C); send(8'h10);
    check_a("off_8x", 0, 1, 7'h3C, 7'h10, 4'h0, 0);

    // Real-time bytes interleaved inside a message.
    send(8'h90); send(8'hF8); send(8'h45); send(8'hFE); send(8'h64);
    check_a("rt", 1, 0, 7'h45, 7'h64, 4'h0, 1);

    // SysEx skip followed by stray data in IDLE.
    pulse_reset();
    check_a("rst2", 0, 0, 7'h00, 7'h00, 4'h0, 0);
    send(8'hF0); send(8'h43); send(8'h12); send(8'hF7);
    send(8'h40);
    check("sysex.on_a", 32'(bus_a.note_on_stb), 32'd0);
    send(8'h40);
    check_a("sysex", 0, 0, 7'h00, 7'h00, 4'h0, 0);
`ifdef MIDI_PARSER_ERR_CNT_EN
    check("err.sysex", 32'(bus_a.err_count), 32'd2);
`endif

    // A status byte mid-message discards the partial message.
    send(8'h90); send(8'h40); send(8'h91);
    check_a("trunc", 0, 0, 7'h00, 7'h00, 4'h0, 0);
`ifdef MIDI_PARSER_ERR_CNT_EN
    check("err.trunc", 32'(bus_a.err_count), 32'd3);
`endif
    send(8'h41); send(8'h42);
    check_a("after_trunc", 1, 0, 7'h41, 7'h42, 4'h1, 1);

    // System common clears running status; following data is dropped.
    send(8'h90); send(8'h3C); send(8'h40);
    send(8'hF6); send(8'h3C); send(8'h00);
    check_a("syscom", 0, 0, 7'h3C, 7'h40, 4'h0, 1);

    // One-data-byte messages never produce events.
    send(8'hC0); send(8'h05); send(8'h06);
    check_a("prog", 0, 0, 7'h3C, 7'h40, 4'h0, 1);

    // Channel filter on the CHANNEL=2 instance.
    pulse_reset();
    send(8'h93); send(8'h40); send(8'h40);
    check("filt.b_on_ch3", 32'(bus_b.note_on_stb), 32'd0);
    check("filt.b_gate_ch3", 32'(bus_b.gate), 32'd0);
    check("filt.a_on_ch3", 32'(bus_a.note_on_stb), 32'd1);
    send(8'h92); send(8'h40); send(8'h40);
    check("filt.b_on_ch2", 32'(bus_b.note_on_stb), 32'd1);
    check("filt.b_chan", 32'(bus_b.channel), 32'd2);
    check("filt.b_gate", 32'(bus_b.gate), 32'd1);

    // Asynchronous reset between the two data bytes.
    send(8'h92); send(8'h40);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid.b_gate", 32'(bus_b.gate), 32'd0);
    check("rstmid.b_note", 32'(bus_b.note), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    send(8'h40);
    check("rstmid.b_on", 32'(bus_b.note_on_stb), 32'd0);
    check("rstmid.b_chan", 32'(bus_b.channel), 32'd0);
    check("rstmid.b_vel", 32'(bus_b.velocity), 32'd0);
    check_a("rstmid.a", 0, 0, 7'h00, 7'h00, 4'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/midi_message_parser.md
Name: midi_message_parser

Overview:
- Receive-side counterpart of the MIDI note sender: consumes bytes from the UART receiver and decodes MIDI channel-voice messages into note events.
- Drives the synth and voice logic with a registered note/velocity/channel, one-cycle note-on/note-off strobes and a held gate for the most recent note.
- Sits between the UART RX byte interface and the tone generator.

Parameters:
- CHANNEL, 0, MIDI channel accepted when OMNI=0 (0..15).
- OMNI, 1, 1 = accept all channels; 0 = accept only CHANNEL.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- rx_byte  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- note  out  7  note number of the last accepted event.
- velocity  out  7  velocity of the last accepted event.
- channel  out  4  channel of the last accepted event.
- note_on_stb  out  1  one-cycle pulse: note-on accepted.
- note_off_stb  out  1  one-cycle pulse: note-off accepted.
- gate  out  1  high while the last note-on note is held.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, running status cleared, state IDLE.
- Byte classes:
  - 0x00-0x7F: data.
  - 0x80-0xEF: channel status.
  - 0xF0: SysEx start.
  - 0xF1-0xF7: system common.
  - 0xF8-0xFF: real-time.
- Real-time bytes are ignored completely in every state: no state, data or running-status change.
- States:
  - IDLE: no running status; data bytes discarded.
  - WAIT_D1: status held; awaiting first data byte.
  - WAIT_D2: first data byte held; awaiting second.
  - SYSEX: discard everything until 0xF7.
- Channel status byte (any state except SYSEX): latch status, go WAIT_D1; any partial message is dropped.
- Message lengths by high nibble:
  - 0x8, 0x9, 0xA, 0xB, 0xE: two data bytes.
  - 0xC, 0xD: one data byte; on its completion return to WAIT_D1 with no output.
- 0xF0: go SYSEX, running status cleared. 0xF7 in SYSEX: go IDLE.
- 0xF1-0xF7 outside SYSEX: clear running status, go IDLE.
- Data in WAIT_D1 with a two-byte status: store d1, go WAIT_D2.
- Data in WAIT_D2: message complete, return to WAIT_D1. This is running status: further data pairs reuse the latched status.
- On completion, if the channel passes the filter:
  - 0x9 with d2≠0: note←d1, velocity←d2, channel←status[3:0], note_on_stb=1, gate←1.
  - 0x8, or 0x9 with d2=0: note←d1, velocity←d2, channel latched, note_off_stb=1. gate←0 only if d1 equals the currently held note; otherwise gate is unchanged.
  - Other status types: no output change.
- A message that fails the channel filter is parsed but produces no output change.
- Latency: strobes and register updates occur on the clock edge following the rx_valid cycle of the final data byte. Strobes last exactly one cycle and are never both high.
- rx_valid on consecutive cycles must be supported, one byte per cycle.
- Status byte arriving mid-message: the partial message is discarded with no strobe.
- Reset mid-message: the partial message is lost and gate is cleared.

Optional Feature:
- Macro: MIDI_PARSER_ERR_CNT_EN.
- Defined: adds output err_count[7:0], an 8-bit saturating counter (stops at 255, reset 0). It increments on:
  - each data byte received in IDLE;
  - each message truncated by a new status byte.
- Undefined: no port and no counter logic; behaviour otherwise identical.

Decomposition:
- Shared package midi_pkg holds:
  - status nibble constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, POLY_AT=4'hA, CC=4'hB, PROG=4'hC, CH_AT=4'hD, PITCH=4'hE);
  - SYSEX_START=8'hF0, SYSEX_END=8'hF7, RT_MIN=8'hF8;
  - the parser state enum.
- midi_note_sender also uses midi_pkg.
- One natural sub-module: midi_byte_classifier, combinational, mapping rx_byte to class and data length.

Test Plan:
- 0x90,0x45,0x64 → note_on_stb 1 cycle after 0x64; note=0x45, velocity=0x64, channel=0, gate=1.
- Running status: 0x91,0x3C,0x40 then 0x3E,0x50 → two note-on strobes with note 0x3C then 0x3E, channel=1; no status resent.
- 0x90,0x3C,0x40 then 0x3C,0x00 → note_off_stb, gate=0. Repeat with off for note 0x3D → note_off_stb but gate stays 1.
- Real-time interleave: 0x90,0xF8,0x45,0xFE,0x64 → identical result to the first scenario.
- SysEx skip: 0xF0,0x43,0x12,0xF7, then 0x40,0x40 → no strobe (IDLE). With MIDI_PARSER_ERR_CNT_EN, err_count=2.
- OMNI=0, CHANNEL=2: 0x93,0x40,0x40 → no strobe; 0x92,0x40,0x40 → note_on_stb. Assert rst between 0x92 and 0x40 → no strobe, all outputs 0.
